// File: rtl/pi_sequencer.sv
// pi_sequencer: steps the shared PI ALU through the left then right channel computations.
// Define INT_DEC_EN to update the integrators only on every fourth control pass.
module pi_sequencer #(
  parameter logic [13:0] PTERM = 14'h3680,
  parameter logic [11:0] ITERM = 12'h500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [11:0] fwd,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res,
  input  logic [15:0] dst,
  output logic [2:0]  src0sel,
  output logic [2:0]  src1sel,
  output logic        multiply,
  output logic        sub,
  output logic        mult2,
  output logic        mult4,
  output logic        saturate,
  output logic [15:0] Accum,
  output logic [15:0] Pcomp,
  output logic [11:0] Icomp,
  output logic [11:0] Error,
  output logic [11:0] Intgrl,
  output logic [13:0] Pterm,
  output logic [11:0] Iterm,
  output logic [11:0] Fwd,
  output logic [11:0] lft,
  output logic [11:0] rht,
  output logic        busy,
  output logic        cyc_done
);

  // state | meaning
  // IDLE  | wait for go          STRT  | conversion requested    WAIT  | wait for A2D result
  // ERR   | Error = Fwd - A2D    INTG  | integrate Error/16      ICOMP | Iterm*Intgrl (2 cycles)
  // PCOMP | Pterm*Error (2 cyc)  ACC1  | Accum = Fwd - Pcomp     OUT   | drive = Accum - Icomp
  typedef enum logic [3:0] {IDLE, STRT, WAIT, ERR, INTG, ICOMP, PCOMP, ACC1, OUT} state_t;

  typedef struct packed {
    logic [2:0] s0;
    logic [2:0] s1;
    logic       mul;
    logic       sb;
    logic       sat;
  } ctl_t;

  state_t      state;
  ctl_t        ctl;
  logic        ch;
  logic        hold;
  logic        intg_en;
  logic [11:0] a2d;
  logic [11:0] intg_l;
  logic [11:0] intg_r;
  logic        unused_a2d;

  function automatic ctl_t ctl_of(input state_t s);
    case (s)
      ERR:     return '{3'b000, 3'b100, 1'b0, 1'b1, 1'b1};
      INTG:    return '{3'b001, 3'b011, 1'b0, 1'b0, 1'b1};
      ICOMP:   return '{3'b001, 3'b001, 1'b1, 1'b0, 1'b0};
      PCOMP:   return '{3'b100, 3'b010, 1'b1, 1'b0, 1'b0};
      ACC1:    return '{3'b011, 3'b100, 1'b0, 1'b1, 1'b0};
      OUT:     return '{3'b010, 3'b000, 1'b0, 1'b1, 1'b1};
      default: return '0;
    endcase
  endfunction

`ifdef INT_DEC_EN
  logic [1:0] pass_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pass_cnt <= '0;
    else if (state == OUT && ch)
      pass_cnt <= pass_cnt + 2'd1;
  end

  assign intg_en = (pass_cnt == 2'b11);
`else
  assign intg_en = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ctl      <= '0;
      ch       <= 1'b0;
      hold     <= 1'b0;
      a2d      <= '0;
      intg_l   <= '0;
      intg_r   <= '0;
      Fwd      <= '0;
      Error    <= '0;
      Icomp    <= '0;
      Pcomp    <= '0;
      Accum    <= '0;
      lft      <= '0;
      rht      <= '0;
      strt_cnv <= 1'b0;
      chnnl    <= '0;
      busy     <= 1'b0;
      cyc_done <= 1'b0;
    end else begin
      strt_cnv <= 1'b0;
      cyc_done <= 1'b0;
      case (state)
        // busy is always low in IDLE; cyc_done blocks a go in the completion cycle
        IDLE: if (go && !cyc_done) begin
          Fwd      <= fwd;
          ch       <= 1'b0;
          busy     <= 1'b1;
          strt_cnv <= 1'b1;
          chnnl    <= 3'b000;
          state    <= STRT;
        end
        STRT: state <= WAIT;
        WAIT: if (cnv_cmplt) begin
          a2d   <= A2D_res;
          ctl   <= ctl_of(ERR);
          state <= ERR;
        end
        ERR: begin
          Error <= dst[11:0];
          ctl   <= ctl_of(INTG);
          state <= INTG;
        end
        INTG: begin
          if (intg_en) begin
            if (ch) intg_r <= dst[11:0];
            else    intg_l <= dst[11:0];
          end
          ctl   <= ctl_of(ICOMP);
          state <= ICOMP;
        end
        ICOMP: if (!hold) hold <= 1'b1;
        else begin
          hold  <= 1'b0;
          Icomp <= dst[11:0];
          ctl   <= ctl_of(PCOMP);
          state <= PCOMP;
        end
        PCOMP: if (!hold) hold <= 1'b1;
        else begin
          hold  <= 1'b0;
          Pcomp <= dst;
          ctl   <= ctl_of(ACC1);
          state <= ACC1;
        end
        ACC1: begin
          Accum <= dst;
          ctl   <= ctl_of(OUT);
          state <= OUT;
        end
        OUT: begin
          ctl <= '0;
          if (!ch) begin
            lft      <= dst[11:0];
            ch       <= 1'b1;
            strt_cnv <= 1'b1;
            chnnl    <= 3'b100;
            state    <= STRT;
          end else begin
            rht      <= dst[11:0];
            busy     <= 1'b0;
            cyc_done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          ctl   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // The ALU reads the conversion straight from the front end; a2d is a captured copy only.
  assign unused_a2d = ^a2d;

  assign Intgrl   = ch ? intg_r : intg_l;
  assign src0sel  = ctl.s0;
  assign src1sel  = ctl.s1;
  assign multiply = ctl.mul;
  assign sub      = ctl.sb;
  assign saturate = ctl.sat;
  assign mult2    = 1'b0;
  assign mult4    = 1'b0;
  assign Pterm    = PTERM;
  assign Iterm    = ITERM;

endmodule

// File: tb/tb_pi_sequencer.sv
// tb_pi_sequencer: pi_sequencer with a behavioural PI ALU and A2D front end,
// checked against a formula-level model of the PI control law.
module tb_pi_sequencer;

  localparam int PTERM_I = 'h3680;
  localparam int ITERM_I = 'h500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] fwd = '0;
  logic [11:0] A2D_res = '0;
  logic [15:0] dst;
  logic        strt_cnv, multiply, sub, mult2, mult4, saturate, busy, cyc_done;
  logic [2:0]  chnnl, src0sel, src1sel;
  logic [15:0] Accum, Pcomp;
  logic [11:0] Icomp, Error, Intgrl, Iterm, Fwd, lft, rht;
  logic [13:0] Pterm;

  int vectors = 0;
  int miscompares = 0;
  int strt_cnt = 0;
  int done_cnt = 0;
  int intg_m[2];
  int lft_m, rht_m, pass_no;

  always #5 clk = ~clk;

  pi_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .fwd(fwd), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .dst(dst), .src0sel(src0sel),
    .src1sel(src1sel), .multiply(multiply), .sub(sub), .mult2(mult2), .mult4(mult4),
    .saturate(saturate), .Accum(Accum), .Pcomp(Pcomp), .Icomp(Icomp), .Error(Error),
    .Intgrl(Intgrl), .Pterm(Pterm), .Iterm(Iterm), .Fwd(Fwd), .lft(lft), .rht(rht),
    .busy(busy), .cyc_done(cyc_done)
  );

  // Behavioural team ALU: dst = src1 +/- src0, or (src0*src1)>>12, optional 12-bit saturation
  logic signed [15:0] a0, a1;
  logic signed [31:0] prod;
  logic signed [16:0] sum;
  always_comb begin
    a0 = '0;
    a1 = '0;
    case (src0sel)
      3'b000: a0 = {4'b0, A2D_res};
      3'b001: a0 = {{4{Intgrl[11]}}, Intgrl};
      3'b010: a0 = {{4{Icomp[11]}}, Icomp};
      3'b011: a0 = Pcomp;
      3'b100: a0 = {2'b0, Pterm};
      default: a0 = '0;
    endcase
    case (src1sel)
      3'b000: a1 = Accum;
      3'b001: a1 = {4'b0, Iterm};
      3'b010: a1 = {{4{Error[11]}}, Error};
      3'b011: a1 = {{8{Error[11]}}, Error[11:4]};
      3'b100: a1 = {4'b0, Fwd};
      default: a1 = '0;
    endcase
    prod = a0 * a1;
    sum  = sub ? ({a1[15], a1} - {a0[15], a0}) : ({a1[15], a1} + {a0[15], a0});
    if (multiply)
      dst = prod[27:12];
    else if (saturate)
      dst = (sum > 17'sd2047) ? 16'h07FF : (sum < -17'sd2048) ? 16'hF800 : sum[15:0];
    else
      dst = sum[15:0];
  end

  always @(posedge clk) begin
    if (strt_cnv) strt_cnt <= strt_cnt + 1;
    if (cyc_done) done_cnt <= done_cnt + 1;
  end

  function automatic int sat12(input int x);
    if (x > 2047) return 2047;
    if (x < -2048) return -2048;
    return x;
  endfunction

  function automatic int sx12(input int x);
    logic signed [11:0] t;
    t = x[11:0];
    return t;
  endfunction

  function automatic int sx16(input int x);
    logic signed [15:0] t;
    t = x[15:0];
    return t;
  endfunction

  task automatic model_reset();
    intg_m[0] = 0;
    intg_m[1] = 0;
    lft_m = 0;
    rht_m = 0;
    pass_no = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // One full two-channel pass; called at a negedge with the DUT idle.
  task automatic run_pass(input logic [11:0] f, input logic [11:0] al, input logic [11:0] ar,
                          input int dly, input bit poke);
    int err, icomp, pcomp, accum, res, n;
    bit upd;
    logic [11:0] a, x_err, x_int, x_icp, x_out, x_old;
    logic [15:0] x_pcp, x_acc;
`ifdef INT_DEC_EN
    upd = (pass_no % 4 == 3);
`else
    upd = 1'b1;
`endif
    fwd = f;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    fwd = 12'($urandom);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_go: got %b want 1", busy);
    end
    for (int c = 0; c < 2; c++) begin
      n = 0;
      while (strt_cnv !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      vectors++;
      if (strt_cnv !== 1'b1 || chnnl !== (c ? 3'b100 : 3'b000)) begin
        miscompares++;
        $display("FAIL strt_cnv_ch%0d: got strt=%b chnnl=%b want strt=1 chnnl=%b",
                 c, strt_cnv, chnnl, c ? 3'b100 : 3'b000);
      end
      @(negedge clk);
      vectors++;
      if (strt_cnv !== 1'b0) begin
        miscompares++;
        $display("FAIL strt_cnv_width_ch%0d: got %b want 0", c, strt_cnv);
      end
      for (int i = 0; i < dly; i++) begin
        if (poke) go = (i == 0);
        @(negedge clk);
      end
      go = 1'b0;
      a = c ? ar : al;
      A2D_res = a;
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;

      err   = sat12(int'(f) - int'(a));
      if (upd) intg_m[c] = sat12(intg_m[c] + (err >>> 4));
      icomp = sx12((intg_m[c] * ITERM_I) >>> 12);
      pcomp = sx16((err * PTERM_I) >>> 12);
      accum = sx16(int'(f) - pcomp);
      res   = sat12(accum - icomp);
      x_err = err[11:0];
      x_int = intg_m[c][11:0];
      x_icp = icomp[11:0];
      x_pcp = pcomp[15:0];
      x_acc = accum[15:0];
      x_out = res[11:0];
      x_old = c ? rht_m[11:0] : lft_m[11:0];

      for (int i = 0; i < 7; i++) begin
        if (poke) begin
          go = (i == 1);
          cnv_cmplt = (i == 1);
        end
        @(negedge clk);
      end
      go = 1'b0;
      cnv_cmplt = 1'b0;
      vectors++;
      if (Error !== x_err || Intgrl !== x_int || Icomp !== x_icp) begin
        miscompares++;
        $display("FAIL err_int_icomp_ch%0d: got %h/%h/%h want %h/%h/%h",
                 c, Error, Intgrl, Icomp, x_err, x_int, x_icp);
      end
      vectors++;
      if (Pcomp !== x_pcp || Accum !== x_acc) begin
        miscompares++;
        $display("FAIL pcomp_accum_ch%0d: got %h/%h want %h/%h", c, Pcomp, Accum, x_pcp, x_acc);
      end
      vectors++;
      if ((c ? rht : lft) !== x_old || cyc_done !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL early_out_ch%0d: got out=%h done=%b busy=%b want out=%h done=0 busy=1",
                 c, c ? rht : lft, cyc_done, busy, x_old);
      end
      @(negedge clk);
      vectors++;
      if ((c ? rht : lft) !== x_out) begin
        miscompares++;
        $display("FAIL drive_ch%0d: got %h want %h", c, c ? rht : lft, x_out);
      end
      vectors++;
      if (cyc_done !== (c == 1) || busy !== (c == 0)) begin
        miscompares++;
        $display("FAIL done_busy_ch%0d: got done=%b busy=%b want done=%b busy=%b",
                 c, cyc_done, busy, c == 1, c == 0);
      end
      if (c == 0) lft_m = res;
      else rht_m = res;
    end
    if (poke) go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    vectors++;
    if (cyc_done !== 1'b0 || strt_cnv !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_done: got done=%b strt=%b busy=%b want 0/0/0", cyc_done, strt_cnv, busy);
    end
    pass_no++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({strt_cnv, chnnl, src0sel, src1sel, multiply, sub, mult2, mult4, saturate, Accum, Pcomp,
         Icomp, Error, Intgrl, Fwd, lft, rht, busy, cyc_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got lft=%h rht=%h busy=%b strt=%b Accum=%h want all zero",
               lft, rht, busy, strt_cnv, Accum);
    end
    vectors++;
    if (Pterm !== 14'h3680 || Iterm !== 12'h500) begin
      miscompares++;
      $display("FAIL gains: got %h/%h want 3680/500", Pterm, Iterm);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_nominal();
    reset_dut();
    run_pass(12'h400, 12'h300, 12'h300, 2, 1'b0);
`ifndef INT_DEC_EN
    vectors++;
    if (Error !== 12'h100 || Intgrl !== 12'h010 || Icomp !== 12'h005) begin
      miscompares++;
      $display("FAIL nominal_eii: got %h/%h/%h want 100/010/005", Error, Intgrl, Icomp);
    end
    vectors++;
    if (Pcomp !== 16'h0368 || Accum !== 16'h0098 || lft !== 12'h093 || rht !== 12'h093) begin
      miscompares++;
      $display("FAIL nominal_out: got %h/%h/%h/%h want 0368/0098/093/093", Pcomp, Accum, lft, rht);
    end
`endif
  endtask

  task automatic test_saturation();
    reset_dut();
    run_pass(12'h000, 12'hFFF, 12'hFFF, 1, 1'b0);
    vectors++;
    if (Error !== 12'h800) begin
      miscompares++;
      $display("FAIL error_sat: got %h want 800", Error);
    end
  endtask

  task automatic test_handshake();
    int s0, d0;
    s0 = strt_cnt;
    d0 = done_cnt;
    run_pass(12'($urandom), 12'($urandom), 12'($urandom), 20, 1'b0);
    @(negedge clk);
    vectors++;
    if (strt_cnt - s0 !== 2 || done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL handshake_counts: got strt=%0d done=%0d want 2/1", strt_cnt - s0, done_cnt - d0);
    end
  endtask

  task automatic test_violations();
    int s0;
    s0 = strt_cnt;
    run_pass(12'($urandom), 12'($urandom), 12'($urandom), 3, 1'b1);
    cnv_cmplt = 1'b1;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (strt_cnt - s0 !== 2 || busy !== 1'b0 || lft !== lft_m[11:0] || rht !== rht_m[11:0]) begin
      miscompares++;
      $display("FAIL violations: got strt=%0d busy=%b lft=%h rht=%h want 2/0/%h/%h",
               strt_cnt - s0, busy, lft, rht, lft_m[11:0], rht_m[11:0]);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    A2D_res = 12'($urandom);
    fwd = 12'($urandom);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    cnv_cmplt = 1'b1;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if (strt_cnv !== 1'b1 || chnnl !== 3'b100) begin
      miscompares++;
      $display("FAIL mid_ch1_start: got strt=%b chnnl=%b want 1/100", strt_cnv, chnnl);
    end
    @(negedge clk);
    cnv_cmplt = 1'b1;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    repeat (5) @(negedge clk);
    s0 = strt_cnt;
    rst = 1'b1;
    #1;
    vectors++;
    if ({strt_cnv, chnnl, src0sel, src1sel, multiply, sub, saturate, Accum, Pcomp, Icomp, Error,
         Intgrl, Fwd, lft, rht, busy, cyc_done} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got lft=%h rht=%h busy=%b Pcomp=%h mul=%b want all zero",
               lft, rht, busy, Pcomp, multiply);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (strt_cnt !== s0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL aborted_pass: got strt=%0d busy=%b want %0d/0", strt_cnt, busy, s0);
    end
    run_pass(12'($urandom), 12'($urandom), 12'($urandom), 1, 1'b0);
  endtask

  task automatic test_decimation();
    logic [11:0] x;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      run_pass(12'h400, 12'h300, 12'h300, 1, 1'b0);
`ifdef INT_DEC_EN
      x = (i == 3) ? 12'h010 : 12'h000;
`else
      x = 12'(16 * (i + 1));
`endif
      vectors++;
      if (Intgrl !== x) begin
        miscompares++;
        $display("FAIL decimation_pass%0d: got %h want %h", i, Intgrl, x);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_pass(12'($urandom), 12'($urandom), 12'($urandom), $urandom_range(0, 5), 1'($urandom));
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_saturation();
    test_handshake();
    test_violations();
    test_reset_mid();
    test_decimation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
